// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and PC constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      StBoot,
      StRun,
      StHalted
   } fetch_state_e;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
   localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch buffer with synchronous flush and occupancy count.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full, do_push, do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign do_push   = push && !full && !flush;
   assign do_pop    = pop && !empty && !flush;
   assign head_data = mem[rd_ptr_q];
   assign count     = count_q;

   // Storage needs no reset: the head is only meaningful while count is nonzero.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
         else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, synchronous-ROM request/response, fetch buffer.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       INST_W    = 32,
   parameter logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(PC_RESET_DEFAULT),
   parameter int unsigned       BUF_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr_out,
   output logic              imem_req_out,
   input  logic [INST_W-1:0] imem_data_in,
   input  logic              redirect_in,
   input  logic [ADDR_W-1:0] redirect_pc_in,
   input  logic              halt_in,
   output logic              inst_valid_out,
   input  logic              inst_ready_in,
   output logic [INST_W-1:0] inst_out,
   output logic [ADDR_W-1:0] inst_pc_out,
   output logic [ADDR_W-1:0] inst_next_pc_out,
   output logic              misalign_out
);

   localparam int unsigned ENTRY_W = ADDR_W + INST_W;
   localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inflight_q;
   logic [ADDR_W-1:0] inflight_pc_q;
   logic              misalign_q;

   logic               req, pop, push, has_space, fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [ENTRY_W-1:0] fifo_head;
   logic [ADDR_W-1:0]  head_pc, target_pc;
   logic [INST_W-1:0]  head_inst;

   assign target_pc      = {redirect_pc_in[ADDR_W-1:2], 2'b00};
   assign inst_valid_out = !fifo_empty && !redirect_in;
   assign pop            = inst_valid_out && inst_ready_in;
   // A redirect in the response cycle kills the returning instruction.
   assign push           = inflight_q && !redirect_in;
   // Reserve a slot for every response still in flight so the buffer cannot overflow.
   assign has_space      = (int'(fifo_count) + int'(inflight_q) - int'(pop)) < int'(BUF_DEPTH);
   assign {head_pc, head_inst} = fifo_head;

   assign imem_addr_out = pc_q;
   assign imem_req_out  = req;
   assign misalign_out  = misalign_q;

   // Head outputs are forced to zero while the buffer is empty.
   always_comb begin
      inst_out         = '0;
      inst_pc_out      = '0;
      inst_next_pc_out = '0;
      if (!fifo_empty) begin
         inst_out         = head_inst;
         inst_pc_out      = head_pc;
         inst_next_pc_out = head_pc + ADDR_W'(PC_INC);
      end
   end

   // Next state, next PC and request: redirect beats halt beats normal fetch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req     = 1'b0;
      if (redirect_in) begin
         pc_d    = target_pc;
         state_d = halt_in ? StHalted : StRun;
      end else begin
         unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
               if (halt_in) begin
                  state_d = StHalted;
               end else if (has_space) begin
                  req  = 1'b1;
                  pc_d = pc_q + ADDR_W'(PC_INC);
               end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StBoot;
         endcase
      end
   end

   // State, PC, in-flight tracking and the sticky misalignment flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= StBoot;
         pc_q          <= PC_RESET;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         misalign_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= req;
         if (req) inflight_pc_q <= pc_q;
         if (redirect_in && (redirect_pc_in[1:0] != 2'b00)) misalign_q <= 1'b1;
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({inflight_pc_q, imem_data_in}),
      .pop       (pop),
      .flush     (redirect_in),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC streams are queued by the driver,
// the monitor pops and compares on every transfer toward decode.
module tb_fetch_unit;

   localparam logic [31:0] PC_RST = 32'h0040_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_data = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_next_pc;
   logic        misalign;

   int total = 0;
   int bad = 0;
   int xfer_cnt = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   fetch_unit dut (
      .clock            (clock),
      .reset            (reset),
      .imem_addr_out    (imem_addr),
      .imem_req_out     (imem_req),
      .imem_data_in     (imem_data),
      .redirect_in      (redirect),
      .redirect_pc_in   (redirect_pc),
      .halt_in          (halt),
      .inst_valid_out   (inst_valid),
      .inst_ready_in    (inst_ready),
      .inst_out         (inst),
      .inst_pc_out      (inst_pc),
      .inst_next_pc_out (inst_next_pc),
      .misalign_out     (misalign)
   );

   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   // Synchronous instruction ROM: data for an address appears one cycle later.
   always_ff @(posedge clock) imem_data <= rom(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h required %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_from(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i * 4));
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Called just after a rising edge; holds redirect for exactly one cycle.
   task automatic do_redirect(input logic [31:0] tgt, input logic h);
      redirect    = 1'b1;
      redirect_pc = tgt;
      halt        = h;
      exp_q.delete();
      if (!h) expect_from({tgt[31:2], 2'b00});
      #2;
      chk("redirect_valid_low", {31'd0, inst_valid}, 32'd0);
      cyc();
      redirect = 1'b0;
      halt     = 1'b0;
   endtask

   task automatic wait_xfers(input string name, input int n, input int budget);
      int start;
      logic reached;
      start   = xfer_cnt;
      reached = 1'b0;
      for (int i = 0; i < budget && !reached; i++) begin
         cyc();
         if (xfer_cnt - start >= n) reached = 1'b1;
      end
      chk(name, {31'd0, reached}, 32'd1);
   endtask

   task automatic do_reset();
      cyc();
      reset    = 1'b0;
      redirect = 1'b0;
      halt     = 1'b0;
      inst_ready = 1'b1;
      expect_from(PC_RST);
      repeat (3) cyc();
      #2;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);
      chk("rst_next_pc", inst_next_pc, 32'd0);
      cyc();
      reset = 1'b1;
      #2;
      chk("boot_no_req", {31'd0, imem_req}, 32'd0);
      cyc(); #2;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, PC_RST);
      cyc(); #2;
      chk("second_addr", imem_addr, PC_RST + 32'd4);
      chk("latency_not_yet", {31'd0, inst_valid}, 32'd0);
      cyc(); #2;
      chk("latency2_valid", {31'd0, inst_valid}, 32'd1);
      chk("latency2_pc", inst_pc, PC_RST);
   endtask

   // Monitor: pops the scoreboard on every transfer and checks hold stability.
   initial begin
      logic        hold_prev;
      logic [31:0] prev_pc, prev_inst, e;
      hold_prev = 1'b0;
      prev_pc   = '0;
      prev_inst = '0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev && inst_valid) begin
               chk("hold_pc", inst_pc, prev_pc);
               chk("hold_inst", inst, prev_inst);
            end
            hold_prev = inst_valid && !inst_ready;
            prev_pc   = inst_pc;
            prev_inst = inst;
            if (inst_valid && inst_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_xfer: got pc %08h required no transfer", inst_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("xfer_pc", inst_pc, e);
                  chk("xfer_inst", inst, rom(e));
                  chk("xfer_next_pc", inst_next_pc, e + 32'd4);
               end
               xfer_cnt++;
            end
         end
      end
   end

   // Driver: directed scenarios followed by a randomized phase.
   initial begin
      int x0, since;
      logic h;
      do_reset();

      for (int i = 0; i < 8; i++) begin
         cyc(); #2;
         chk("stream_valid", {31'd0, inst_valid}, 32'd1);
      end

      // Backpressure: requests stop, head holds, order resumes afterwards.
      cyc();
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cyc();
         #2;
         chk("stall_no_req", {31'd0, imem_req}, 32'd0);
         chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      end
      cyc();
      inst_ready = 1'b1;
      wait_xfers("stall_resume", 6, 20);

      // Redirect with a buffered entry and a response in flight.
      inst_ready = 1'b0;
      do_redirect(32'h0040_0100, 1'b0);
      inst_ready = 1'b1;
      wait_xfers("redirect_resume", 4, 20);

      // Misaligned redirect target.
      chk("misalign_before", {31'd0, misalign}, 32'd0);
      do_redirect(32'h0040_0102, 1'b0);
      #2;
      chk("misalign_set", {31'd0, misalign}, 32'd1);
      chk("misalign_req_addr", imem_addr, 32'h0040_0100);
      wait_xfers("misalign_resume", 4, 20);
      chk("misalign_sticky", {31'd0, misalign}, 32'd1);

      // Redirect together with halt, then resume by a later redirect.
      do_redirect(32'h0000_0010, 1'b1);
      for (int i = 0; i < 6; i++) begin
         #2;
         chk("halted_no_req", {31'd0, imem_req}, 32'd0);
         chk("halted_no_valid", {31'd0, inst_valid}, 32'd0);
         cyc();
      end
      do_redirect(32'h0000_0020, 1'b0);
      #2;
      chk("resume_req", {31'd0, imem_req}, 32'd1);
      chk("resume_addr", imem_addr, 32'h0000_0020);
      wait_xfers("resume_xfers", 4, 20);

      // PC wrap-around.
      do_redirect(32'hFFFF_FFFC, 1'b0);
      wait_xfers("wrap_xfers", 4, 20);

      // Plain halt: in-flight and buffered entries drain, no new requests.
      cyc();
      halt = 1'b1;
      cyc();
      halt = 1'b0;
      repeat (4) cyc();
      #2;
      chk("halt_no_req", {31'd0, imem_req}, 32'd0);
      chk("halt_drained", {31'd0, inst_valid}, 32'd0);
      do_redirect(32'h0040_0200, 1'b0);
      wait_xfers("halt_resume", 3, 20);

      // Reset in the middle of streaming.
      do_reset();
      chk("misalign_cleared", {31'd0, misalign}, 32'd0);

      // Randomized traffic.
      x0    = xfer_cnt;
      since = 0;
      for (int i = 0; i < 800; i++) begin
         cyc();
         halt       = 1'b0;
         inst_ready = ($urandom % 4) != 0;
         since++;
         if (since >= 40 || ($urandom % 100) < 4) begin
            h = ($urandom % 8) == 0;
            do_redirect($urandom, h);
            since = 0;
         end else if (($urandom % 100) < 3) begin
            halt = 1'b1;
         end
      end
      halt = 1'b0;
      chk("rand_progress", {31'd0, (xfer_cnt - x0) > 150}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, PC and instruction-memory address width.
REQ-002 SHALL provide parameter INST_W, default 32, instruction width.
REQ-003 SHALL provide parameter PC_RESET, default 32'h0040_0000, first fetch address after reset.
REQ-004 SHALL provide parameter BUF_DEPTH, default 2, fetch-buffer entries; power of two, minimum 2.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port imem_addr_out  output  ADDR_W  fetch address to synchronous instruction ROM.
REQ-008 SHALL have port imem_req_out  output  1  fetch issued this cycle.
REQ-009 SHALL have port imem_data_in  input  INST_W  ROM data, valid exactly one cycle after the request.
REQ-010 SHALL have port redirect_in  input  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc_in  input  ADDR_W  target address for the redirect.
REQ-012 SHALL have port halt_in  input  1  stop issuing new fetches.
REQ-013 SHALL have port inst_valid_out  output  1  buffer head valid toward decode.
REQ-014 SHALL have port inst_ready_in  input  1  decode accepts the head.
REQ-015 SHALL have the ports inst_out (INST_W), inst_pc_out (ADDR_W) and inst_next_pc_out (ADDR_W), all outputs carrying the head instruction, its address and its address + 4.
REQ-016 SHALL have port misalign_out  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-017 SHALL implement FSM states BOOT, RUN and HALTED; BOOT lasts exactly one cycle after reset release and issues no request before moving to RUN.
REQ-018 In RUN, SHALL assert imem_req_out with imem_addr_out = PC when (buffer count + in-flight - pop) < BUF_DEPTH, then advance PC by 4.
REQ-019 PC arithmetic SHALL be modulo 2^ADDR_W; 0xFFFF_FFFC + 4 wraps to 0.
REQ-020 SHALL write a response into the buffer at the end of the cycle after its request, unless the response has been killed; the entry is visible on the outputs the following cycle (request-to-valid latency 2).
REQ-021 A transfer SHALL occur when inst_valid_out && inst_ready_in; the head is popped and the next entry is presented the next cycle.
REQ-022 With inst_ready_in held high and no redirect, SHALL sustain one instruction per cycle.
REQ-023 On redirect_in: buffer cleared, any in-flight response killed, PC <= {redirect_pc_in[ADDR_W-1:2],2'b00}, and no request issued that cycle; the target is fetched the next cycle.
REQ-024 inst_valid_out SHALL equal (buffer not empty) && !redirect_in; no transfer occurs in a redirect cycle.
REQ-025 A redirect with redirect_pc_in[1:0] != 0 SHALL set misalign_out; it stays set until reset.
REQ-026 halt_in in RUN SHALL move to HALTED: no new requests; the in-flight response and buffered entries still drain; a redirect in HALTED returns to RUN.
REQ-027 Priority SHALL be redirect > halt > normal fetch; a simultaneous redirect_in and halt_in redirects and enters HALTED.
REQ-028 Buffer SHALL never overflow; when full, requests stop (imem_req_out=0) and PC holds.
REQ-029 inst_out, inst_pc_out and inst_next_pc_out SHALL be stable while inst_valid_out && !inst_ready_in.

Reset
REQ-030 While reset is low: state BOOT, PC = PC_RESET, buffer empty, in-flight cleared, misalign_out=0, imem_req_out=0, inst_valid_out=0, data outputs 0.
REQ-031 Reset asserted mid-operation SHALL discard the buffer and the in-flight response; the first request after release is to PC_RESET.

Structure
REQ-032 SHALL place the FSM state enum, the default PC_RESET and the PC increment constant (4) in shared package cpu_pkg.
REQ-033 The buffer SHALL be sub-module fetch_fifo (parametrised width/depth, push, pop, flush, count).

Verification
REQ-034 Reset release, ready=1: requests at 0x0040_0000, 0x0040_0004, ...; first inst_valid_out two cycles after the first request; then one instruction per cycle.
REQ-035 ready=0 for 5 cycles, BUF_DEPTH=2: at most 2 entries buffered, imem_req_out drops, outputs stable; on ready=1, order preserved with no gaps or duplicates.
REQ-036 redirect_in to 0x0040_0100 while the buffer is full and a response is in flight: no stale instruction ever appears; the next valid carries inst_pc_out=0x0040_0100.
REQ-037 redirect_pc_in=0x0040_0102: misalign_out=1 and persists; fetch proceeds from 0x0040_0100.
REQ-038 halt_in asserted together with redirect_in to 0x10: one fetch of 0x10 is not issued and the state is HALTED; a later redirect to 0x20 resumes fetching at 0x20.
REQ-039 Redirect to 0xFFFF_FFFC with ready=1: the instructions that follow have inst_pc_out 0xFFFF_FFFC then 0x0000_0000; inst_next_pc_out for the first is 0.
